dram_arbiter: RTL and testbench

Shares the single external 32-bit DRAM request/response port between two requesters. Port 0 is the DMA controller; port 1 is reserved for the planned instruction/frame fetch unit. The block sits between the requesters and the top-level dram_* pins. It grants one transaction at a time, using round-robin priority and a per-transaction timeout watchdog. Address, data and operation are registered at grant, so the DRAM side sees stable values for the whole transaction.

---
 rtl/dram_arbiter_pkg.sv | 21 ++
 rtl/dram_arbiter_timeout_counter.sv | 30 +++
 rtl/dram_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_dram_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arbiter_pkg.sv
// Shared constants, state encoding and round-robin helper for the DRAM port arbiter.
package dram_arbiter_pkg;

  localparam int DRAM_ADDR_W = 24;
  localparam int DRAM_DATA_W = 32;
  localparam int TMO_CNT_W   = 16;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_RD      = 2'd1,
    ARB_WR      = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

  // Contention goes to the port that did not hold the last grant.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last_owner);
    if (req0 && req1) return ~last_owner;
    return req1;
  endfunction

endpackage

// File: rtl/dram_arbiter_timeout_counter.sv
// Per-transaction watchdog: clearable up-counter with an equality compare against the limit.
module dram_arbiter_timeout_counter
  import dram_arbiter_pkg::*;
#(
  parameter int W = TMO_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == limit_i);

endmodule

// File: rtl/dram_arbiter.sv
// Two-port round-robin arbiter in front of the single DRAM request/response port.
//   state       | meaning
//   ARB_IDLE    | no grant; arbitrate requesting ports
//   ARB_RD      | read outstanding, waiting for dram_data_valid or watchdog
//   ARB_WR      | write outstanding, waiting for dram_write_complete or watchdog
//   ARB_RELEASE | one dead cycle so the finished requester can drop its request
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DRAM_ADDR_W,
  parameter int DATA_W   = DRAM_DATA_W,
  parameter int TIMEOUT  = 1024,
  parameter int P0_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_req_read,
  input  logic              m0_req_write,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_data_valid,
  output logic              m0_write_complete,
  output logic              m0_error,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_req_read,
  input  logic              m1_req_write,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_data_valid,
  output logic              m1_write_complete,
  output logic              m1_error,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_data_out,
  output logic              dram_req_read,
  output logic              dram_req_write,
  input  logic [DATA_W-1:0] dram_data_in,
  input  logic              dram_data_valid,
  input  logic              dram_write_complete,
  output logic              owner,
  output logic              busy,
  output logic              timeout_seen
);

  localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT - 1);
  // Owner resets to port 1 so that port 0 wins the first contention when P0_FIRST is set.
  localparam logic OWNER_RST = (P0_FIRST != 0);

  arb_state_e              state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    busy_q, busy_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    req_rd_q, req_rd_d;
  logic                    req_wr_q, req_wr_d;
  logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;
  logic [1:0]              dv_q, dv_d;
  logic [1:0]              wc_q, wc_d;
  logic [1:0]              err_q, err_d;
  logic                    tseen_q, tseen_d;

  logic req0, req1, win, win_wr, grant, cnt_en, expired;

  assign req0   = m0_req_read | m0_req_write;
  assign req1   = m1_req_read | m1_req_write;
  assign win    = rr_pick(req0, req1, owner_q);
  assign win_wr = win ? m1_req_write : m0_req_write;
  assign grant  = (state_q == ARB_IDLE) && (req0 || req1);
  assign cnt_en = (state_q == ARB_RD) || (state_q == ARB_WR);

  dram_arbiter_timeout_counter #(.W(TMO_CNT_W)) u_tmo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (grant),
    .en_i      (cnt_en),
    .limit_i   (TMO_LIMIT),
    .expired_o (expired)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    busy_d   = busy_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    req_rd_d = req_rd_q;
    req_wr_d = req_wr_q;
    rdata_d  = rdata_q;
    dv_d     = '0;
    wc_d     = '0;
    err_d    = '0;
    tseen_d  = tseen_q;

    case (state_q)
      ARB_IDLE: begin
        if (grant) begin
          owner_d = win;
          busy_d  = 1'b1;
          addr_d  = win ? m1_addr : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
          if (win_wr) begin
            state_d  = ARB_WR;
            req_wr_d = 1'b1;
          end else begin
            state_d  = ARB_RD;
            req_rd_d = 1'b1;
          end
        end
      end
      ARB_RD: begin
        // A response on the expiry cycle still completes normally.
        if (dram_data_valid) begin
          rdata_d[owner_q] = dram_data_in;
          dv_d[owner_q]    = 1'b1;
          req_rd_d         = 1'b0;
          state_d          = ARB_RELEASE;
        end else if (expired) begin
          err_d[owner_q] = 1'b1;
          tseen_d        = 1'b1;
          req_rd_d       = 1'b0;
          state_d        = ARB_RELEASE;
        end
      end
      ARB_WR: begin
        if (dram_write_complete) begin
          wc_d[owner_q] = 1'b1;
          req_wr_d      = 1'b0;
          state_d       = ARB_RELEASE;
        end else if (expired) begin
          err_d[owner_q] = 1'b1;
          tseen_d        = 1'b1;
          req_wr_d       = 1'b0;
          state_d        = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        busy_d  = 1'b0;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWNER_RST;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      req_rd_q <= 1'b0;
      req_wr_q <= 1'b0;
      rdata_q  <= '0;
      dv_q     <= '0;
      wc_q     <= '0;
      err_q    <= '0;
      tseen_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      req_rd_q <= req_rd_d;
      req_wr_q <= req_wr_d;
      rdata_q  <= rdata_d;
      dv_q     <= dv_d;
      wc_q     <= wc_d;
      err_q    <= err_d;
      tseen_q  <= tseen_d;
    end
  end

  assign dram_addr         = addr_q;
  assign dram_data_out     = wdata_q;
  assign dram_req_read     = req_rd_q;
  assign dram_req_write    = req_wr_q;
  assign m0_rdata          = rdata_q[0];
  assign m1_rdata          = rdata_q[1];
  assign m0_data_valid     = dv_q[0];
  assign m1_data_valid     = dv_q[1];
  assign m0_write_complete = wc_q[0];
  assign m1_write_complete = wc_q[1];
  assign m0_error          = err_q[0];
  assign m1_error          = err_q[1];
  assign owner             = owner_q;
  assign busy              = busy_q;
  assign timeout_seen      = tseen_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: vector table, hand sequences, randomized transactions.
module tb_dram_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] m0_addr, m1_addr, dram_addr;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, dram_data_out, dram_data_in;
  logic        m0_req_read, m0_req_write, m1_req_read, m1_req_write;
  logic        m0_data_valid, m0_write_complete, m0_error;
  logic        m1_data_valid, m1_write_complete, m1_error;
  logic        dram_req_read, dram_req_write, dram_data_valid, dram_write_complete;
  logic        owner, busy, timeout_seen;
  logic [5:0]  pulses;

  assign pulses = {m1_error, m1_write_complete, m1_data_valid,
                   m0_error, m0_write_complete, m0_data_valid};

  dram_arbiter #(.ADDR_W(24), .DATA_W(32), .TIMEOUT(TMO), .P0_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_req_read(m0_req_read),
    .m0_req_write(m0_req_write), .m0_rdata(m0_rdata), .m0_data_valid(m0_data_valid),
    .m0_write_complete(m0_write_complete), .m0_error(m0_error),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_req_read(m1_req_read),
    .m1_req_write(m1_req_write), .m1_rdata(m1_rdata), .m1_data_valid(m1_data_valid),
    .m1_write_complete(m1_write_complete), .m1_error(m1_error),
    .dram_addr(dram_addr), .dram_data_out(dram_data_out),
    .dram_req_read(dram_req_read), .dram_req_write(dram_req_write),
    .dram_data_in(dram_data_in), .dram_data_valid(dram_data_valid),
    .dram_write_complete(dram_write_complete),
    .owner(owner), .busy(busy), .timeout_seen(timeout_seen)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state: last grant owner, per-port read data, sticky timeout flag.
  logic        own_m;
  logic [31:0] rdata_m [2];
  logic        tseen_m;

  typedef struct {
    logic [1:0]  r0;   // {write, read}
    logic [1:0]  r1;
    logic [23:0] a0, a1;
    logic [31:0] d0, d1;
    int          k;    // response cycle inside RD/WR; >= TMO means no response
    logic        wrong;
    logic [31:0] rdat;
    logic        exp_own;
    logic        exp_wr;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic clear_reqs();
    m0_req_read = 0; m0_req_write = 0; m1_req_read = 0; m1_req_write = 0;
  endtask

  // Caller is at a negedge with the arbiter idle; returns at a negedge with it idle again.
  task automatic run_txn(input logic [1:0] r0, input logic [1:0] r1,
                         input logic [23:0] a0, input logic [23:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input int k, input logic wrong, input logic [31:0] rdat,
                         input logic exp_own, input logic exp_wr);
    logic [23:0] ea;
    logic [31:0] ed;
    logic [5:0]  ep;
    logic        timed_out;
    int          base;
    ea = exp_own ? a1 : a0;
    ed = exp_own ? d1 : d0;
    timed_out = (k >= TMO);
    m0_req_read = r0[0]; m0_req_write = r0[1]; m0_addr = a0; m0_wdata = d0;
    m1_req_read = r1[0]; m1_req_write = r1[1]; m1_addr = a1; m1_wdata = d1;
    @(posedge clk); #1;
    chk("grant_rd", dram_req_read, !exp_wr);
    chk("grant_wr", dram_req_write, exp_wr);
    chk("grant_addr", dram_addr, ea);
    chk("grant_data", dram_data_out, ed);
    chk("grant_owner", owner, exp_own);
    chk("grant_busy", busy, 1'b1);
    @(negedge clk);
    clear_reqs();
    m0_addr = 24'($urandom); m1_addr = 24'($urandom);
    m0_wdata = $urandom; m1_wdata = $urandom;
    for (int c = 0; c < TMO; c++) begin
      chk("hold_req", {dram_req_read, dram_req_write}, {!exp_wr, exp_wr});
      chk("hold_addr", dram_addr, ea);
      chk("hold_quiet", pulses, 6'b0);
      if (c == k) begin
        dram_data_in = rdat;
        if (exp_wr) dram_write_complete = 1'b1;
        else        dram_data_valid = 1'b1;
      end else if (wrong && c == 0) begin
        dram_data_in = ~rdat;
        if (exp_wr) dram_data_valid = 1'b1;
        else        dram_write_complete = 1'b1;
      end
      @(negedge clk);
      dram_data_valid = 1'b0; dram_write_complete = 1'b0; dram_data_in = $urandom;
      if (c == k) break;
    end
    base = exp_own ? 3 : 0;
    ep = '0;
    if (timed_out)   ep[base+2] = 1'b1;
    else if (exp_wr) ep[base+1] = 1'b1;
    else             ep[base]   = 1'b1;
    if (!timed_out && !exp_wr) rdata_m[exp_own] = rdat;
    if (timed_out) tseen_m = 1'b1;
    chk("done_pulse", pulses, ep);
    chk("done_req", {dram_req_read, dram_req_write}, 2'b00);
    chk("done_busy", busy, 1'b1);
    chk("done_rdata0", m0_rdata, rdata_m[0]);
    chk("done_rdata1", m1_rdata, rdata_m[1]);
    chk("done_tseen", timeout_seen, tseen_m);
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_quiet", pulses, 6'b0);
    own_m = exp_own;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'b01, 2'b00, 24'h000123, 24'h0,      32'h0,        32'h0,        5,   1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[1] = '{2'b10, 2'b10, 24'h000100, 24'h000200, 32'h11111111, 32'h22222222, 3,   1'b0, 32'h0,        1'b1, 1'b1};
    tbl[2] = '{2'b10, 2'b10, 24'h000101, 24'h000201, 32'h11111111, 32'h22222222, 0,   1'b0, 32'h0,        1'b0, 1'b1};
    tbl[3] = '{2'b10, 2'b10, 24'h000102, 24'h000202, 32'h11111111, 32'h22222222, 15,  1'b1, 32'h0,        1'b1, 1'b1};
    tbl[4] = '{2'b10, 2'b10, 24'h000103, 24'h000203, 32'h11111111, 32'h22222222, 7,   1'b0, 32'h0,        1'b0, 1'b1};
    tbl[5] = '{2'b00, 2'b01, 24'h0,      24'h000555, 32'h0,        32'h0,        100, 1'b0, 32'h0,        1'b1, 1'b0};
    tbl[6] = '{2'b11, 2'b00, 24'h000ABC, 24'h0,      32'h5A5A5A5A, 32'h0,        2,   1'b1, 32'h0,        1'b0, 1'b1};
    tbl[7] = '{2'b01, 2'b01, 24'h000010, 24'h000020, 32'h0,        32'h0,        15,  1'b0, 32'hCAFEF00D, 1'b1, 1'b0};
    tbl[8] = '{2'b00, 2'b10, 24'h0,      24'hFFFFFF, 32'h0,        32'h33333333, 4,   1'b0, 32'h0,        1'b1, 1'b1};
    tbl[9] = '{2'b01, 2'b01, 24'h000030, 24'h000040, 32'h0,        32'h0,        0,   1'b1, 32'h0BADF00D, 1'b0, 1'b0};

    clear_reqs();
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    dram_data_in = 0; dram_data_valid = 0; dram_write_complete = 0;
    rst_n = 1'b1;
    own_m = 1'b1; rdata_m[0] = 0; rdata_m[1] = 0; tseen_m = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_owner", owner, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dram", {dram_req_read, dram_req_write, dram_addr, dram_data_out}, 58'h0);
    chk("rst_pulses", pulses, 6'b0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
    chk("rst_tseen", timeout_seen, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both ports writing continuously: grants alternate starting with port 0.
    @(negedge clk);
    m0_addr = 24'h000AAA; m0_wdata = 32'h11111111; m0_req_write = 1'b1;
    m1_addr = 24'h000BBB; m1_wdata = 32'h22222222; m1_req_write = 1'b1;
    for (int g = 0; g < 4; g++) begin
      int n;
      logic eo;
      n = 0;
      while (!dram_req_write && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("rr_wait", n, (g == 0) ? 1 : 2);
      eo = ~own_m;
      chk("rr_owner", owner, eo);
      chk("rr_data", dram_data_out, eo ? 32'h22222222 : 32'h11111111);
      chk("rr_addr", dram_addr, eo ? 24'h000BBB : 24'h000AAA);
      own_m = eo;
      dram_write_complete = 1'b1;
      @(negedge clk);
      dram_write_complete = 1'b0;
      chk("rr_pulse", pulses, eo ? 6'b010000 : 6'b000010);
      chk("rr_release", {dram_req_write, busy}, 2'b01);
      if (g == 3) clear_reqs();
    end
    @(negedge clk);
    chk("rr_idle", busy, 1'b0);

    for (int i = 0; i < 10; i++)
      run_txn(tbl[i].r0, tbl[i].r1, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1,
              tbl[i].k, tbl[i].wrong, tbl[i].rdat, tbl[i].exp_own, tbl[i].exp_wr);

    // Stray DRAM responses while idle must be ignored.
    for (int i = 0; i < 2; i++) begin
      dram_data_in = 32'hBAD0BAD0; dram_data_valid = 1'b1; dram_write_complete = 1'b1;
      @(negedge clk);
      dram_data_valid = 1'b0; dram_write_complete = 1'b0;
      chk("stray_pulse", pulses, 6'b0);
      chk("stray_rdata", {m0_rdata, m1_rdata}, {rdata_m[0], rdata_m[1]});
      chk("stray_req", {dram_req_read, dram_req_write, busy}, 3'b000);
    end

    // Reset in the middle of a read.
    chk("tseen_sticky", timeout_seen, tseen_m);
    m0_addr = 24'h000777; m0_req_read = 1'b1;
    @(negedge clk);
    chk("mid_req", dram_req_read, 1'b1);
    m0_req_read = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {dram_req_read, dram_req_write}, 2'b00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_owner", owner, 1'b1);
    chk("mid_rst_tseen", timeout_seen, 1'b0);
    chk("mid_rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
    own_m = 1'b1; rdata_m[0] = 0; rdata_m[1] = 0; tseen_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(2'b01, 2'b01, 24'h000321, 24'h000654, 32'h0, 32'h0, 3, 1'b0,
            32'h600DD00D, 1'b0, 1'b0);

    // Randomized transactions against the model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] r0, r1;
      logic       w, ewr;
      r0 = 2'($urandom_range(0, 3));
      r1 = 2'($urandom_range(0, 3));
      if (r0 == 2'b00 && r1 == 2'b00) r1 = 2'b01;
      w   = (r0 != 0 && r1 != 0) ? ~own_m : (r1 != 0);
      ewr = w ? r1[1] : r0[1];
      run_txn(r0, r1, 24'($urandom), 24'($urandom), $urandom, $urandom,
              $urandom_range(0, 19), 1'($urandom_range(0, 1)), $urandom, w, ewr);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
